// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronisers, ps2_clk glitch filter, framing, parity/stop
// checks and stall timeout. Optional make/break prefix decode is enabled by PS2_BREAK_DECODE_EN.
module ps2_rx_frame #(
    parameter int DATA_BITS      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 key_release,
    output logic                 key_ext
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    logic                   filt_clk;
    logic                   filt_prev;
    logic [FCW-1:0]         filt_cnt;
    logic                   fall;

    logic [1:0]             state;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic [TCW-1:0]         to_cnt;
    logic                   timeout_hit;
    logic                   par_ok;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Both pins idle high, so the synchronisers reset to 1 to avoid a fake start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // The filtered clock only moves once the synchronised level has disagreed for FILTER_LEN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    assign fall        = filt_prev & ~filt_clk;
    assign busy        = (state != S_IDLE);
    assign timeout_hit = busy && !fall && (to_cnt == TO_LAST);
    assign par_ok      = ^{shreg, par_bit};

    always_ff @(posedge clk) begin
        if (rst || fall || !busy || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TCW'(1);
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    localparam logic [DATA_BITS-1:0] PFX_EXT = DATA_BITS'(8'hE0);
    localparam logic [DATA_BITS-1:0] PFX_BRK = DATA_BITS'(8'hF0);

    logic ext_pend;
    logic brk_pend;
    logic key_ext_q;
    logic key_rel_q;

    assign key_ext     = key_ext_q;
    assign key_release = key_rel_q;
`else
    assign key_ext     = 1'b0;
    assign key_release = 1'b0;
`endif

    // Strobes are registered off the stop-bit fall so they appear one cycle later for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            key_ext_q  <= 1'b0;
            key_rel_q  <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
            key_ext_q  <= 1'b0;
            key_rel_q  <= 1'b0;
`endif
            if (timeout_hit) begin
                state     <= S_IDLE;
                frame_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
`endif
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!data_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {data_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= data_s;
                        state   <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        if (!data_s || !par_ok) begin
                            frame_err  <= ~data_s;
                            parity_err <= data_s;
`ifdef PS2_BREAK_DECODE_EN
                            ext_pend   <= 1'b0;
                            brk_pend   <= 1'b0;
`endif
                        end else begin
`ifdef PS2_BREAK_DECODE_EN
                            if (shreg == PFX_EXT) begin
                                ext_pend <= 1'b1;
                            end else if (shreg == PFX_BRK) begin
                                brk_pend <= 1'b1;
                            end else begin
                                rx_valid  <= 1'b1;
                                rx_data   <= shreg;
                                key_ext_q <= ext_pend;
                                key_rel_q <= brk_pend;
                                ext_pend  <= 1'b0;
                                brk_pend  <= 1'b0;
                            end
`else
                            rx_valid <= 1'b1;
                            rx_data  <= shreg;
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: an event-queue model of expected strobes, checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_ps2_rx_frame;

    localparam int DB   = 8;
    localparam int SS   = 2;
    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 20;
    localparam int LAT  = SS + FL + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ps2_clk;
    logic          ps2_data;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;
    logic          key_release;
    logic          key_ext;

    ps2_rx_frame #(
        .DATA_BITS(DB), .SYNC_STAGES(SS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy), .key_release(key_release), .key_ext(key_ext)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = rx_valid, 1 = parity_err, 2 = frame_err
    typedef struct {
        int         kind;
        logic [7:0] data;
        bit         ext;
        bit         rel;
        int         earliest;
        int         latest;
    } ev_t;

    ev_t        q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    logic [7:0] exp_rx = 8'h00;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input bit e, input bit r,
                        input int lo, input int hi);
        ev_t ev;
        ev.kind = kind; ev.data = d; ev.ext = e; ev.rel = r; ev.earliest = lo; ev.latest = hi;
        q.push_back(ev);
    endtask

    // Outcome of a complete frame from the protocol rules: stop bit first, then odd parity,
    // then (optionally) prefix tracking.
    task automatic model_frame(input logic [7:0] d, input bit par, input bit stop, input int tf);
        if (!stop) begin
            push(2, 8'h00, 0, 0, tf + 1, tf + LAT);
            m_ext = 0; m_brk = 0;
        end else if (((^d) ^ par) == 1'b0) begin
            push(1, 8'h00, 0, 0, tf + 1, tf + LAT);
            m_ext = 0; m_brk = 0;
        end else begin
`ifdef PS2_BREAK_DECODE_EN
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else begin
                push(0, d, m_ext, m_brk, tf + 1, tf + LAT);
                m_ext = 0; m_brk = 0;
            end
`else
            push(0, d, 0, 0, tf + 1, tf + LAT);
`endif
        end
    endtask

    ev_t e;
    int  k;
    always @(negedge clk) begin
        if (!rst) begin
            k = int'(rx_valid) + int'(parity_err) + int'(frame_err);
            check("single_strobe", (k > 1) ? 32'd1 : 32'd0, 32'd0);
            if (k == 1) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", {29'd0, rx_valid, parity_err, frame_err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", rx_valid ? 0 : (parity_err ? 1 : 2), e.kind);
                    check("strobe_window", (cyc >= e.earliest && cyc <= e.latest) ? 1 : 0, 1);
                    if (rx_valid) begin
                        n_valid++;
                        check("rx_data_on_valid", rx_data, e.data);
                        check("key_ext_on_valid", key_ext, e.ext);
                        check("key_release_on_valid", key_release, e.rel);
                        exp_rx = e.data;
                    end
                end
            end
            if (!rx_valid) begin
                check("rx_data_hold", rx_data, exp_rx);
                check("key_flags_idle", {key_ext, key_release}, 2'b00);
            end
            if (q.size() > 0 && cyc > q[0].latest) begin
                check("missing_strobe", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic fall_bit(input bit b, output int tf);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        tf = cyc;
    endtask

    task automatic rise();
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stop);
        logic [10:0] bits;
        int          tf;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            fall_bit(bits[i], tf);
            if (i == 10) model_frame(d, par, stop, tf);
            rise();
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits, output int tf);
        fall_bit(1'b0, tf);
        rise();
        for (int i = 0; i < nbits; i++) begin
            fall_bit(d[i], tf);
            rise();
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        int tf;
        int n_busy;
        int v0;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_strobes", {rx_valid, parity_err, frame_err}, 3'b000);
        check("reset_busy", busy, 1'b0);
        repeat (10) @(negedge clk);

        // 1: good 0x1C
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t1_rx_data", rx_data, 8'h1C);
        check("t1_busy_after", busy, 1'b0);

        // 2: parity error keeps old data
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t2_rx_data_held", rx_data, 8'h1C);

        // 3: bad stop bit
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t3_rx_data_held", rx_data, 8'h1C);

        // 4: stalled frame times out, then a good frame
        send_partial(8'h5A, 3, tf);
        push(2, 8'h00, 0, 0, tf + TO, tf + TO + LAT);
        m_ext = 0; m_brk = 0;
        repeat (50) @(negedge clk);
        check("t4_busy_mid", busy, 1'b1);
        repeat (TO + 20) @(negedge clk);
        check("t4_busy_after_timeout", busy, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("t4_rx_data", rx_data, 8'h5A);

        // 5: short glitch while idle
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        ps2_clk = 1'b1;
        n_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) n_busy++;
        end
        check("t5_glitch_busy_cycles", n_busy, 0);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);

        // mid-frame reset discards silently
        send_partial(8'h33, 2, tf);
        repeat (HALF) @(negedge clk);
        check("rst_busy_before", busy, 1'b1);
        rst = 1'b1;
        m_ext = 0; m_brk = 0; exp_rx = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_midframe_busy", busy, 1'b0);
        check("rst_midframe_rx_data", rx_data, 8'h00);
        repeat (2 * LAT) @(negedge clk);

        // 6: prefixes then 0x75
        v0 = n_valid;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("t6_rx_data", rx_data, 8'h75);
`ifdef PS2_BREAK_DECODE_EN
        check("t6_valid_count", n_valid - v0, 1);
`else
        check("t6_valid_count", n_valid - v0, 3);
`endif

        repeat (100) @(negedge clk);
        check("events_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Parametrised PS/2 device-to-host receiver, the next generation of the keyboard front end. It synchronises and glitch-filters the raw ps2_clk/ps2_data pins and frames bits on ps2_clk falling edges. It checks odd parity and the stop bit, and aborts stalled frames on timeout. Validated bytes go downstream as a single-cycle strobe.

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first
SYNC_STAGES, 2, flip-flop synchroniser depth on both pins (min 2)
FILTER_LEN, 8, clk cycles a synchronised ps2_clk level must stay stable before the filtered clock follows it
TIMEOUT_CYCLES, 50000, clk cycles without a falling edge before a partial frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
ps2_data  input  1  raw PS/2 data pin (asynchronous)
rx_data  output  DATA_BITS  last accepted byte
rx_valid  output  1  one-cycle strobe: rx_data updated
parity_err  output  1  one-cycle strobe: parity mismatch
frame_err  output  1  one-cycle strobe: bad stop bit or timeout
busy  output  1  high while a frame is in progress (state != IDLE)
key_release  output  1  break-prefix flag qualified by rx_valid
key_ext  output  1  extended-prefix flag qualified by rx_valid

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. On rst: state=IDLE, rx_data=0, all strobes/flags=0, filtered clock=1, synchronisers=1, counters=0. A reset mid-frame discards the partial frame with no error strobe.
- Filter: the filtered clock takes the synchronised level only after it has been stable for FILTER_LEN consecutive cycles; shorter glitches are ignored.
- Edge detect: fall = previous filtered & ~current filtered. ps2_data is sampled from the last sync stage in the fall cycle.
- Frame format: start(0), DATA_BITS data LSB first, odd parity (total ones across data+parity is odd), stop(1).
- IDLE: on fall with data=0, go to DATA and clear the bit counter. On fall with data=1, stay in IDLE with no error.
- DATA: on each fall, shift the bit into the MSB (shift right). After DATA_BITS bits, go to PARITY.
- PARITY: on fall, latch the parity bit and go to STOP.
- STOP: on fall, return to IDLE. The strobe issued depends on the stop bit and parity:
  - stop=0: frame_err only, regardless of parity.
  - stop=1 and parity bad: parity_err.
  - stop=1 and parity good: rx_valid, and rx_data loads the shifted byte.
- Strobe timing: every strobe asserts exactly 1 cycle after the stop-bit fall cycle and lasts exactly 1 cycle. rx_data changes only on rx_valid and otherwise holds its value.
- Timeout: the counter clears on every fall and counts while state != IDLE. When it reaches TIMEOUT_CYCLES-1, issue a one-cycle frame_err, go to IDLE and discard the partial data. A fall in the same cycle as expiry wins: the counter clears and no timeout is raised.
- Latency: rx_valid follows the stop-bit pin falling edge by at most SYNC_STAGES+FILTER_LEN+2 cycles.
- Width: counters are sized with $clog2 of their parameter; the bit counter is $clog2(DATA_BITS+1) wide.

Optional Feature:
Macro PS2_BREAK_DECODE_EN (requires DATA_BITS=8).
- Defined:
  - A good byte 0xE0 sets ext_pend; a good byte 0xF0 sets brk_pend. Neither prefix byte produces rx_valid.
  - The next good non-prefix byte produces rx_valid with key_ext=ext_pend and key_release=brk_pend, then both pending flags clear.
  - parity_err, frame_err and rst also clear both pending flags.
  - key_ext/key_release are valid only in the rx_valid cycle and are 0 otherwise.
- Undefined: every good byte produces rx_valid; key_ext and key_release are tied to 0.

Test Plan:
1. Frame 0x1C, parity 0, stop 1 -> one rx_valid pulse, rx_data=0x1C, no error strobes, busy low after the stop bit.
2. Frame 0x1C with parity 1 after test 1 -> parity_err pulse, no rx_valid, rx_data stays 0x1C.
3. Frame 0x5A, parity 1, stop 0 -> frame_err pulse, parity_err low, no rx_valid.
4. Start bit plus 3 data bits, then ps2_clk held high for >TIMEOUT_CYCLES -> frame_err at expiry and busy drops; a following 0x5A frame (parity 1) gives rx_valid with rx_data=0x5A.
5. ps2_clk low pulse of FILTER_LEN-2 cycles while idle, with data=0 -> busy stays 0 and no strobe.
6. Good frames 0xE0, 0xF0, 0x75 (parity 0) -> with PS2_BREAK_DECODE_EN: one rx_valid, rx_data=0x75, key_ext=1, key_release=1. Without the macro: three rx_valid pulses, key_ext and key_release always 0.
